// File: rtl/dilithium_input_packer.sv
// Host-to-core input packer for the Dilithium 64-bit input stream.
// Pairs of 32-bit host words become one 64-bit beat (low word first).
// Beats are queued in a small FIFO that drives the core handshake.
// A lone final word is zero-padded, and the final beat of a message carries last_o.
module dilithium_input_packer #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [31:0]      host_data,
    input  logic             host_last,
    output logic             valid_o,
    input  logic             ready_o,
    output logic [63:0]      data_o,
    output logic             last_o,
    output logic [CNT_W-1:0] beat_count,
    output logic             busy
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam int ENT_W  = 65;

    localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(FIFO_DEPTH);
    localparam logic [FCNT_W-1:0] FCNT_ZERO = {FCNT_W{1'b0}};
    localparam logic [FCNT_W-1:0] FCNT_ONE  = {{(FCNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  BCNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  BCNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  BCNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    // FIFO entry: {last, data[63:0]}
    logic [ENT_W-1:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [FCNT_W-1:0]   fifo_count_r;
    logic [31:0]         half_r;
    logic                half_valid_r;
    logic [CNT_W-1:0]    beat_count_r;

    logic                host_ready_s;
    logic                fifo_nempty_s;
    logic                xfer_s;
    logic                push_s;
    logic                pop_s;
    logic [ENT_W-1:0]    push_entry_s;
    logic [ENT_W-1:0]    head_entry_s;

    // Handshake decode and push/pop qualification; start pre-empts any host word.
    always_comb begin
        host_ready_s  = 1'b0;
        fifo_nempty_s = (fifo_count_r != FCNT_ZERO);
        head_entry_s  = fifo_mem_r[rd_ptr_r];
        if (state_r == ST_RUN) begin
            host_ready_s = (fifo_count_r < DEPTH_C);
        end else begin
            host_ready_s = 1'b0;
        end
        xfer_s = host_valid & host_ready_s & ~start;
        push_s = xfer_s & (half_valid_r | host_last);
        pop_s  = fifo_nempty_s & ready_o;
        if (half_valid_r) begin
            push_entry_s = {host_last, host_data, half_r};
        end else begin
            push_entry_s = {host_last, 32'h0000_0000, host_data};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: start always (re)arms, last transfer drains, empty FIFO idles.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else if (xfer_s && host_last) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else if (pop_s && (fifo_count_r == FCNT_ONE)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only (no path from ready_o to host_ready).
    always_comb begin
        host_ready = host_ready_s;
        busy       = (state_r != ST_IDLE);
        valid_o    = fifo_nempty_s;
        if (fifo_nempty_s) begin
            data_o = head_entry_s[63:0];
            last_o = head_entry_s[64];
        end else begin
            data_o = 64'h0000_0000_0000_0000;
            last_o = 1'b0;
        end
    end

    // FIFO storage: only written on push, so the head is stable while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {ENT_W{1'b0}};
            end
        end else if (push_s && !start) begin
            fifo_mem_r[wr_ptr_r] <= push_entry_s;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy, half-word register and beat counter; start flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            fifo_count_r <= FCNT_ZERO;
            half_r       <= 32'h0000_0000;
            half_valid_r <= 1'b0;
            beat_count_r <= BCNT_ZERO;
        end else if (start) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            fifo_count_r <= FCNT_ZERO;
            half_valid_r <= 1'b0;
            beat_count_r <= BCNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                if (beat_count_r != BCNT_MAX) begin
                    beat_count_r <= beat_count_r + BCNT_ONE;
                end else begin
                    beat_count_r <= beat_count_r;
                end
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + FCNT_ONE;
                2'b01:   fifo_count_r <= fifo_count_r - FCNT_ONE;
                default: fifo_count_r <= fifo_count_r;
            endcase
            if (xfer_s) begin
                if (half_valid_r || host_last) begin
                    half_valid_r <= 1'b0;
                end else begin
                    half_r       <= host_data;
                    half_valid_r <= 1'b1;
                end
            end else begin
                half_valid_r <= half_valid_r;
            end
        end
    end

    assign beat_count = beat_count_r;

endmodule

// File: tb/tb_dilithium_input_packer.sv
// Bench for dilithium_input_packer: directed plan steps plus randomized messages,
// checked every cycle against a queue-based model of the beat stream.
module tb_dilithium_input_packer;

    localparam int DEPTH = 2;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          host_valid;
    logic          host_ready;
    logic [31:0]   host_data;
    logic          host_last;
    logic          valid_o;
    logic          ready_o;
    logic [63:0]   data_o;
    logic          last_o;
    logic [CW-1:0] beat_count;
    logic          busy;

    always #5 clk = ~clk;

    dilithium_input_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_data(host_data), .host_last(host_last),
        .valid_o(valid_o), .ready_o(ready_o), .data_o(data_o), .last_o(last_o),
        .beat_count(beat_count), .busy(busy)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Model: queue of beats waiting for the core, pending half word, message phase.
    logic [64:0] m_q[$];
    bit          m_run, m_drain, m_half_v;
    logic [31:0] m_half;
    int          m_cnt;
    logic [64:0] dut_log[$];
    bit          last_xfer;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_hr();
        return m_run && (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_half_v = 1'b0;
        m_cnt    = 0;
        m_run    = 1'b0;
        m_drain  = 1'b0;
    endtask

    task automatic check_all();
        bit v;
        v = (m_q.size() > 0);
        chk("host_ready", {64'd0, host_ready}, {64'd0, exp_hr()});
        chk("valid_o", {64'd0, valid_o}, {64'd0, v});
        chk("data_o", {1'b0, data_o}, v ? {1'b0, m_q[0][63:0]} : 65'd0);
        chk("last_o", {64'd0, last_o}, v ? {64'd0, m_q[0][64]} : 65'd0);
        chk("beat_count", {49'd0, beat_count}, 65'(m_cnt));
        chk("busy", {64'd0, busy}, {64'd0, (m_run | m_drain)});
    endtask

    // One clock: predict handshakes from the model, advance model, check outputs.
    task automatic tick();
        bit xfer, pop;
        xfer = host_valid && exp_hr() && !start;
        pop  = (m_q.size() > 0) && ready_o;
        if (valid_o && ready_o && !start) dut_log.push_back({last_o, data_o});
        @(posedge clk);
        last_xfer = xfer;
        if (start) begin
            m_q.delete();
            m_half_v = 1'b0;
            m_cnt    = 0;
            m_run    = 1'b1;
            m_drain  = 1'b0;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                if (m_cnt < 65535) m_cnt++;
                if (m_drain && m_q.size() == 0) m_drain = 1'b0;
            end
            if (xfer) begin
                if (m_half_v) begin
                    m_q.push_back({host_last, host_data, m_half});
                    m_half_v = 1'b0;
                end else if (host_last) begin
                    m_q.push_back({1'b1, 32'h0, host_data});
                end else begin
                    m_half   = host_data;
                    m_half_v = 1'b1;
                end
                if (host_last) begin
                    m_run   = 1'b0;
                    m_drain = 1'b1;
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        dut_log.delete();
    endtask

    task automatic send_word(input logic [31:0] w, input bit last);
        int k;
        host_valid = 1'b1;
        host_data  = w;
        host_last  = last;
        k = 0;
        do begin
            tick();
            k++;
        end while (!last_xfer && k < 40);
        chk("send_timeout", {64'd0, last_xfer}, 65'd1);
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        chk("idle_timeout", {64'd0, busy}, 65'd0);
    endtask

    initial begin
        logic [31:0] w[8];
        int len;
        rst = 1'b0; start = 1'b0; host_valid = 1'b0; host_data = 32'h0;
        host_last = 1'b0; ready_o = 1'b0;
        model_reset();
        do_reset();

        // 1: even message, ready_o high
        ready_o = 1'b1;
        do_start();
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b1);
        wait_idle();
        chk("t1_nbeats", 65'(dut_log.size()), 65'd2);
        chk("t1_beat0", dut_log[0], {1'b0, 64'h2222222211111111});
        chk("t1_beat1", dut_log[1], {1'b1, 64'h4444444433333333});
        chk("t1_count", {49'd0, beat_count}, 65'd2);

        // 2: odd message, final word zero-padded
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        do_start();
        send_word(w[0], 1'b0);
        send_word(w[1], 1'b0);
        send_word(w[2], 1'b1);
        wait_idle();
        chk("t2_nbeats", 65'(dut_log.size()), 65'd2);
        chk("t2_beat0", dut_log[0], {1'b0, w[1], w[0]});
        chk("t2_beat1", dut_log[1], {1'b1, 32'h0, w[2]});

        // 3: backpressure with 6 words
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        ready_o = 1'b0;
        do_start();
        for (int i = 0; i < 4; i++) send_word(w[i], 1'b0);
        chk("t3_full_ready", {64'd0, host_ready}, 65'd0);
        host_valid = 1'b1;
        host_data  = w[4];
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_off", {64'd0, last_xfer}, 65'd0);
            chk("t3_stall_data", {1'b0, data_o}, {1'b0, w[1], w[0]});
        end
        ready_o = 1'b1;
        send_word(w[4], 1'b0);
        send_word(w[5], 1'b1);
        wait_idle();
        chk("t3_nbeats", 65'(dut_log.size()), 65'd3);
        chk("t3_beat0", dut_log[0], {1'b0, w[1], w[0]});
        chk("t3_beat1", dut_log[1], {1'b0, w[3], w[2]});
        chk("t3_beat2", dut_log[2], {1'b1, w[5], w[4]});

        // 4: abort after 3 words, then a 2-word message
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        do_start();
        for (int i = 0; i < 3; i++) send_word(w[i], 1'b0);
        host_valid = 1'b1;
        host_data  = w[4];
        do_start();
        host_valid = 1'b0;
        chk("t4_valid", {64'd0, valid_o}, 65'd0);
        chk("t4_count", {49'd0, beat_count}, 65'd0);
        send_word(w[3], 1'b0);
        send_word(w[4], 1'b1);
        wait_idle();
        chk("t4_nbeats", 65'(dut_log.size()), 65'd1);
        chk("t4_beat", dut_log[0], {1'b1, w[4], w[3]});

        // 5: reset mid-DRAIN with one beat pending
        ready_o = 1'b0;
        do_start();
        send_word($urandom, 1'b0);
        send_word($urandom, 1'b1);
        chk("t5_drain_busy", {64'd0, busy}, 65'd1);
        do_reset();
        chk("t5_valid", {64'd0, valid_o}, 65'd0);
        chk("t5_busy", {64'd0, busy}, 65'd0);
        ready_o = 1'b1;
        dut_log.delete();
        for (int i = 0; i < 5; i++) tick();
        chk("t5_no_beat", 65'(dut_log.size()), 65'd0);

        // 6: continuous words with ready_o high
        do_start();
        host_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            host_data = $urandom;
            host_last = (i == 9);
            chk("t6_host_ready", {64'd0, host_ready}, 65'd1);
            tick();
            chk("t6_xfer", {64'd0, last_xfer}, 65'd1);
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
        wait_idle();
        chk("t6_nbeats", 65'(dut_log.size()), 65'd5);
        chk("t6_count", {49'd0, beat_count}, 65'd5);

        // Random messages with random host_valid / ready_o
        for (int m = 0; m < 6; m++) begin
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) w[i] = $urandom;
            do_start();
            for (int i = 0; i < len; i++) begin
                int k;
                host_data = w[i];
                host_last = (i == len - 1);
                k = 0;
                do begin
                    host_valid = 1'($urandom_range(0, 1));
                    ready_o    = 1'($urandom_range(0, 1));
                    tick();
                    k++;
                end while (!last_xfer && k < 200);
                chk("rnd_timeout", {64'd0, last_xfer}, 65'd1);
            end
            host_valid = 1'b0;
            host_last  = 1'b0;
            ready_o    = 1'b1;
            wait_idle();
            chk("rnd_nbeats", 65'(dut_log.size()), 65'((len + 1) / 2));
            for (int b = 0; b < (len + 1) / 2; b++) begin
                logic [31:0] hi;
                hi = (2 * b + 1 < len) ? w[2 * b + 1] : 32'h0;
                if (b < dut_log.size())
                    chk("rnd_beat", dut_log[b], {(2 * b + 2 >= len), hi, w[2 * b]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/dilithium_input_packer.md
Name: dilithium_input_packer

Overview:
Upstream feeder for the Dilithium core's 64-bit input stream. Accepts 32-bit words from the host-side bus and packs each pair into one 64-bit beat, low word first. Beats pass through a small output FIFO that drives the core's valid_i/ready_i/data_i handshake. A partial final word pair is zero-padded, and the last beat of each message is tagged.

Parameters:
- FIFO_DEPTH, 2, output FIFO entries (power of two, >=2)
- CNT_W, 16, width of the beat counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- start  in  1  single-cycle strobe from the start edge detector; arms a new message
- host_valid  in  1  host word valid
- host_ready  out  1  packer can accept a host word
- host_data  in  32  host word
- host_last  in  1  qualifies host_data as the final word of the message
- valid_o  out  1  beat valid toward the core's valid_i
- ready_o  in  1  core ready (core's ready_i)
- data_o  out  64  packed beat toward the core's data_i
- last_o  out  1  high with the final beat of the message
- beat_count  out  CNT_W  beats accepted by the core since start
- busy  out  1  message in progress (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous) forces the following:
  - outputs: host_ready=0, valid_o=0, data_o=0, last_o=0, beat_count=0, busy=0
  - internal: FIFO empty, half register empty, state=IDLE
- States: IDLE, RUN, DRAIN.
  - IDLE: host_ready=0. start -> RUN; clears the FIFO, the half flag and beat_count.
  - RUN: host_ready = (fifo_count < FIFO_DEPTH). host_ready is registered-state-only and has no combinational path from ready_o.
  - RUN: a host transfer occurs when host_valid & host_ready.
  - RUN: a transfer with the half flag clear stores host_data in half_reg and sets the flag. No push.
  - RUN: a transfer with the half flag set pushes {host_data, half_reg} (data_o[31:0] = earlier word) and clears the flag.
  - RUN: a transfer with host_last=1 and the half flag clear pushes {32'h0, host_data} immediately.
  - RUN: either host_last push carries last=1, and the state moves to DRAIN.
  - DRAIN: host_ready=0. When the FIFO empties after the last=1 beat pops -> IDLE; busy drops the same cycle.
- Output handshake:
  - valid_o = FIFO non-empty; data_o and last_o show the FIFO head.
  - Pop on valid_o & ready_o. beat_count increments on each pop and saturates at all-ones.
  - data_o and last_o are held stable while valid_o=1 and ready_o=0.
- Push and pop in the same cycle leave fifo_count unchanged. Push while full cannot occur, because host_ready gates it.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count is a separate counter, 0..FIFO_DEPTH.
- start while busy aborts the message:
  - FIFO flushed, half flag cleared, beat_count=0, state=RUN (re-armed) next cycle.
  - Any host word presented that cycle is dropped.
- start in DRAIN behaves the same as start while busy.
- host_last is ignored unless a transfer occurs.
- Latency: first valid_o one cycle after the transfer that completes a beat. Sustained throughput is 1 beat per 2 host words with no bubbles when ready_o=1.
- Reset asserted mid-message: immediate return to reset values. No beat is emitted after reset deasserts until a new start.

Test Plan:
1. Reset, start, 4 words 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on the 4th), ready_o=1 -> expected:
   - beats 0x2222222211111111, then 0x4444444433333333 with last_o=1
   - beat_count=2, busy falls after the 2nd pop
2. Odd message: 3 words A, B, C (last on C) -> expected:
   - beats {B,A}, then {0x00000000,C} with last_o=1
3. Backpressure: ready_o=0, host streams 6 words -> expected:
   - host_ready drops after the 4th word (FIFO full with 2 beats); 5th word held off
   - data_o stable while stalled
   - releasing ready_o lets the remaining beats drain in order; none lost or duplicated
4. start asserted after 3 words of an unfinished message -> expected:
   - valid_o=0 and beat_count=0 next cycle
   - a new 2-word message yields exactly one beat with last_o=1
5. rst pulsed low mid-DRAIN with one beat pending -> expected:
   - valid_o=0, busy=0 immediately
   - no beat emitted until the next start
6. Simultaneous push/pop, ready_o=1, continuous host words -> expected:
   - fifo_count never exceeds 1
   - one beat every 2 cycles; host_ready never deasserts in RUN
